// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream packer: FSM state and status flags.
// lane_cnt is sized for up to 256 lanes; narrower counters are zero-extended.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        PK_EMPTY = 2'd0,
        PK_FILL  = 2'd1,
        PK_FLUSH = 2'd2
    } packer_state_t;

    typedef struct packed {
        logic [7:0]  lane_cnt;
        logic        flush_pending;
        logic [31:0] nb_words;
    } flags_packer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes.
// Modports: source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_packer_outbuf.sv
// One-entry output register for the packer (valid/data/strb).
// Ports: i_clk, i_rst (async, high), i_clear, i_load + i_data/i_strb in,
//        i_ready from the consumer; o_valid/o_data/o_strb out, o_free when
//        a load this cycle cannot overwrite an unconsumed word.
module hwpe_stream_packer_outbuf #(
    parameter int unsigned DW = 128
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [DW-1:0]   i_data,
    input  logic [DW/8-1:0] i_strb,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_strb,
    output logic          o_free
);
    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic [DW/8-1:0] r_strb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_strb  <= i_strb;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A load may replace a word that is leaving this same cycle.
    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_strb  = r_strb;
endmodule

// File: rtl/hwpe_stream_sink_packer.sv
// Packs RATIO narrow beats (lane 0 = LSBs) into one wide registered word.
// Ports: clk_i, rst_i (async, high), clear_i (sync), flush_i (emit partial
//        word), push_i narrow sink, pop_o wide source, flags_o status.
// Define HWPE_STREAM_PACKER_WORD_CNT_EN to count pop_o handshakes in
// flags_o.nb_words; otherwise nb_words is tied to 0.
module hwpe_stream_sink_packer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 32,
    parameter int unsigned DATA_WIDTH_OUT = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    flush_i,
    hwpe_stream_intf_stream.sink    push_i,
    hwpe_stream_intf_stream.source  pop_o,
    output flags_packer_t           flags_o
);
    localparam int unsigned RATIO = DATA_WIDTH_OUT / DATA_WIDTH_IN;
    localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned SI    = DATA_WIDTH_IN / 8;
    localparam int unsigned SO    = DATA_WIDTH_OUT / 8;
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
        RATIO * DATA_WIDTH_IN != DATA_WIDTH_OUT) begin : g_bad_ratio
        $error("packer: DATA_WIDTH_OUT/DATA_WIDTH_IN must be a power of two >= 2");
    end

    packer_state_t       r_state;
    logic [LW-1:0]       r_lane_cnt;
    logic [DATA_WIDTH_OUT-1:0] r_buf_data;
    logic [SO-1:0]       r_buf_strb;

    logic                w_in_flush;
    logic                w_last;
    logic                w_out_free;
    logic                w_out_valid;
    logic                w_push_ready;
    logic                w_push_hs;
    logic                w_complete;
    logic                w_flush_req;
    logic                w_load;
    logic [LW-1:0]       w_lane_next;
    logic [DATA_WIDTH_OUT-1:0] w_merge_data;
    logic [SO-1:0]       w_merge_strb;
    logic [31:0]         w_nb_words;

    assign w_in_flush   = (r_state == PK_FLUSH);
    assign w_last       = (r_lane_cnt == LAST);
    assign w_push_ready = ~w_in_flush & ~(w_last & ~w_out_free);
    assign w_push_hs    = push_i.valid & w_push_ready;
    assign w_complete   = w_push_hs & w_last;
    // A flush with nothing buffered is dropped; a completing beat absorbs it.
    assign w_flush_req  = flush_i & ~w_in_flush & ~w_complete &
                          ((r_lane_cnt != '0) | w_push_hs);
    assign w_load       = w_complete |
                          ((w_flush_req | w_in_flush) & w_out_free);
    assign w_lane_next  = r_lane_cnt + LW'(w_push_hs);

    // Unfilled lanes stay zero because the buffer is cleared on every load.
    always_comb begin
        w_merge_data = r_buf_data;
        w_merge_strb = r_buf_strb;
        for (int l = 0; l < RATIO; l++) begin
            if (w_push_hs && (r_lane_cnt == LW'(l))) begin
                w_merge_data[l*DATA_WIDTH_IN +: DATA_WIDTH_IN] = push_i.data;
                w_merge_strb[l*SI +: SI] = push_i.strb;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= PK_EMPTY;
            r_lane_cnt <= '0;
            r_buf_data <= '0;
            r_buf_strb <= '0;
        end else if (clear_i) begin
            r_state    <= PK_EMPTY;
            r_lane_cnt <= '0;
            r_buf_data <= '0;
            r_buf_strb <= '0;
        end else if (w_load) begin
            r_state    <= PK_EMPTY;
            r_lane_cnt <= '0;
            r_buf_data <= '0;
            r_buf_strb <= '0;
        end else begin
            r_lane_cnt <= w_lane_next;
            r_buf_data <= w_merge_data;
            r_buf_strb <= w_merge_strb;
            if (w_flush_req) begin
                r_state <= PK_FLUSH;
            end else if (!w_in_flush) begin
                r_state <= (w_lane_next != '0) ? PK_FILL : PK_EMPTY;
            end
        end
    end

    hwpe_stream_packer_outbuf #(
        .DW (DATA_WIDTH_OUT)
    ) u_outbuf (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clear (clear_i),
        .i_load  (w_load),
        .i_data  (w_merge_data),
        .i_strb  (w_merge_strb),
        .i_ready (pop_o.ready),
        .o_valid (w_out_valid),
        .o_data  (pop_o.data),
        .o_strb  (pop_o.strb),
        .o_free  (w_out_free)
    );

`ifdef HWPE_STREAM_PACKER_WORD_CNT_EN
    logic [31:0] r_nb_words;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_nb_words <= '0;
        end else if (clear_i) begin
            r_nb_words <= '0;
        end else if (w_out_valid && pop_o.ready) begin
            r_nb_words <= r_nb_words + 32'd1;
        end
    end

    assign w_nb_words = r_nb_words;
`else
    assign w_nb_words = '0;
`endif

    assign push_i.ready          = w_push_ready;
    assign pop_o.valid           = w_out_valid;
    assign flags_o.lane_cnt      = 8'(r_lane_cnt);
    assign flags_o.flush_pending = w_in_flush;
    assign flags_o.nb_words      = w_nb_words;
endmodule

// File: tb/tb_hwpe_stream_sink_packer.sv
// Bench for hwpe_stream_sink_packer, 32 -> 128 bits (4 lanes).
// A queue model predicts every output word; directed steps pin timing.
module tb_hwpe_stream_sink_packer;
    import hwpe_stream_package::*;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic flush;
    flags_packer_t flags;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  push_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) pop_if ();

    hwpe_stream_sink_packer #(
        .DATA_WIDTH_IN  (32),
        .DATA_WIDTH_OUT (128)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .flush_i (flush),
        .push_i  (push_if),
        .pop_o   (pop_if),
        .flags_o (flags)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int stalls = 0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Model: beats collected since the last emitted word, and the
    // ordered list of words the DUT still owes on pop_o.
    logic [31:0]  beats[$];
    logic [127:0] qd[$];
    logic [15:0]  qs[$];

    task automatic emit();
        logic [127:0] w = '0;
        logic [15:0]  s = '0;
        foreach (beats[i]) begin
            w[i*32 +: 32] = beats[i];
            s[i*4 +: 4]   = 4'hF;
        end
        qd.push_back(w);
        qs.push_back(s);
        beats.delete();
    endtask

    logic         hold = 1'b0;
    logic [127:0] hold_d;
    logic [15:0]  hold_s;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                beats.delete(); qd.delete(); qs.delete();
                hold = 1'b0;
            end else begin
                if (pop_if.valid) begin
                    if (qd.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_word: got %h, none expected",
                                 pop_if.data);
                    end else begin
                        chk("out_data", pop_if.data, qd[0]);
                        chk("out_strb", 128'(pop_if.strb), 128'(qs[0]));
                    end
                    if (hold) begin
                        chk("hold_data", pop_if.data, hold_d);
                        chk("hold_strb", 128'(pop_if.strb), 128'(hold_s));
                    end
                end else if (hold) begin
                    chk("hold_valid", 128'(pop_if.valid), 128'd1);
                end
                if (clear) begin
                    beats.delete(); qd.delete(); qs.delete();
                    hold = 1'b0;
                end else begin
                    if (pop_if.valid && pop_if.ready && qd.size() > 0) begin
                        void'(qd.pop_front());
                        void'(qs.pop_front());
                    end
                    if (push_if.valid && push_if.ready) begin
                        beats.push_back(push_if.data);
                        if (beats.size() == 4) emit();
                        else if (flush) emit();
                    end else if (flush && beats.size() > 0) begin
                        emit();
                    end
                    hold   = pop_if.valid & ~pop_if.ready;
                    hold_d = pop_if.data;
                    hold_s = pop_if.strb;
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] d);
        bit ok = 1'b0;
        push_if.valid = 1'b1;
        push_if.data  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = push_if.ready;
            if (!ok) stalls++;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: beat %h not taken in 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        push_if.valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; flush = 1'b0;
        push_if.valid = 1'b0; push_if.data = '0; push_if.strb = 4'hF;
        pop_if.ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_valid", 128'(pop_if.valid), 128'd0);
        chk("rst_data", pop_if.data, 128'd0);
        chk("rst_strb", 128'(pop_if.strb), 128'd0);
        chk("rst_lane", 128'(flags.lane_cnt), 128'd0);
        chk("rst_pending", 128'(flags.flush_pending), 128'd0);
        chk("rst_nb_words", 128'(flags.nb_words), 128'd0);
        rst = 1'b0;
        #1;
        chk("rst_push_ready", 128'(push_if.ready), 128'd1);

        // Full throughput, two words.
        stalls = 0;
        push_beat(32'h1); push_beat(32'h2); push_beat(32'h3);
        chk("t1_valid_early", 128'(pop_if.valid), 128'd0);
        push_beat(32'h4);
        chk("t1_valid_w0", 128'(pop_if.valid), 128'd1);
        chk("t1_data_w0", pop_if.data,
            128'h00000004_00000003_00000002_00000001);
        chk("t1_strb_w0", 128'(pop_if.strb), 128'hFFFF);
        push_beat(32'h5); push_beat(32'h6); push_beat(32'h7);
        push_beat(32'h8);
        chk("t1_valid_w1", 128'(pop_if.valid), 128'd1);
        chk("t1_data_w1", pop_if.data,
            128'h00000008_00000007_00000006_00000005);
        idle(2);
        chk("t1_stalls", 128'(stalls), 128'd0);

        // Partial word by flush.
        push_beat(32'hA); push_beat(32'hB); push_beat(32'hC);
        push_if.valid = 1'b0;
        pulse_flush();
        chk("t2_valid", 128'(pop_if.valid), 128'd1);
        chk("t2_data", pop_if.data, 128'h0000000C_0000000B_0000000A);
        chk("t2_strb", 128'(pop_if.strb), 128'h0FFF);
        chk("t2_lane", 128'(flags.lane_cnt), 128'd0);
        idle(2);

        // Backpressure on the completing beat.
        pop_if.ready = 1'b0;
        push_beat(32'h11); push_beat(32'h12);
        push_beat(32'h13); push_beat(32'h14);
        push_beat(32'h21); push_beat(32'h22); push_beat(32'h23);
        push_if.valid = 1'b1;
        push_if.data  = 32'h24;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready_low", 128'(push_if.ready), 128'd0);
        end
        chk("t3_held", pop_if.data, 128'h00000014_00000013_00000012_00000011);
        @(posedge clk); #1;
        pop_if.ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_high", 128'(push_if.ready), 128'd1);
        @(posedge clk); #1;
        push_if.valid = 1'b0;
        chk("t3_valid_w1", 128'(pop_if.valid), 128'd1);
        chk("t3_data_w1", pop_if.data,
            128'h00000024_00000023_00000022_00000021);
        idle(2);

        // Flush while the output register is busy.
        pop_if.ready = 1'b0;
        push_beat(32'h71); push_beat(32'h72);
        push_beat(32'h73); push_beat(32'h74);
        push_beat(32'h81); push_beat(32'h82);
        push_if.valid = 1'b0;
        pulse_flush();
        chk("t3b_pending", 128'(flags.flush_pending), 128'd1);
        chk("t3b_ready", 128'(push_if.ready), 128'd0);
        chk("t3b_lane", 128'(flags.lane_cnt), 128'd2);
        idle(2);
        chk("t3b_pending2", 128'(flags.flush_pending), 128'd1);
        pop_if.ready = 1'b1;
        @(posedge clk); #1;
        chk("t3b_data", pop_if.data, 128'h00000082_00000081);
        chk("t3b_strb", 128'(pop_if.strb), 128'h00FF);
        chk("t3b_pending0", 128'(flags.flush_pending), 128'd0);
        idle(2);

        // Flush on the completing beat, then flush while empty.
        push_beat(32'h31); push_beat(32'h32); push_beat(32'h33);
        flush = 1'b1;
        push_beat(32'h34);
        flush = 1'b0;
        push_if.valid = 1'b0;
        chk("t4_data", pop_if.data, 128'h00000034_00000033_00000032_00000031);
        chk("t4_strb", 128'(pop_if.strb), 128'hFFFF);
        @(posedge clk); #1;
        chk("t4_no_extra", 128'(pop_if.valid), 128'd0);
        pulse_flush();
        chk("t4_empty_flush", 128'(pop_if.valid), 128'd0);
        idle(1);
        chk("t4_empty_flush2", 128'(pop_if.valid), 128'd0);
        chk("t4_empty_pending", 128'(flags.flush_pending), 128'd0);

        // Asynchronous reset mid-word with a word held.
        pop_if.ready = 1'b0;
        push_beat(32'h51); push_beat(32'h52);
        push_beat(32'h53); push_beat(32'h54);
        push_beat(32'h41); push_beat(32'h42);
        push_if.valid = 1'b0;
        chk("t5_held", 128'(pop_if.valid), 128'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 128'(pop_if.valid), 128'd0);
        chk("t5_rst_lane", 128'(flags.lane_cnt), 128'd0);
        chk("t5_rst_data", pop_if.data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pop_if.ready = 1'b1;
        push_beat(32'h61); push_beat(32'h62);
        push_beat(32'h63); push_beat(32'h64);
        chk("t5_clean", pop_if.data, 128'h00000064_00000063_00000062_00000061);
        chk("t5_clean_strb", 128'(pop_if.strb), 128'hFFFF);
        idle(2);

        // Word counter over five words after a soft clear.
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t6_clear_nb", 128'(flags.nb_words), 128'd0);
        chk("t6_clear_valid", 128'(pop_if.valid), 128'd0);
        for (int i = 0; i < 20; i++) push_beat(32'h100 + 32'(i));
        idle(3);
`ifdef HWPE_STREAM_PACKER_WORD_CNT_EN
        chk("t6_nb_words", 128'(flags.nb_words), 128'd5);
`else
        chk("t6_nb_words", 128'(flags.nb_words), 128'd0);
`endif

        for (int k = 0; k < 20 && qd.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain", 128'(qd.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
